// File: rtl/vregfile_pkg.sv
// Shared definitions for the vector register file read sequencer.
// Holds the sequencer state encoding, skid buffer depth and length clamp helper.
// Imported by vregfile_rdseq and vregfile_rdseq_skid.
package vregfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rdseq_state_e;

    // Two entries cover the single in-flight RAM read plus one held element.
    localparam int SKID_DEPTH = 2;

    // Commands longer than the register file read each register at most once.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned numregs);
        return (len > numregs) ? numregs : len;
    endfunction

endpackage

// File: rtl/vregfile_rdseq_skid.sv
// Small FIFO of {last,data} that catches register file read data.
// Latency: written at the clock edge, visible on out_* the following cycle.
// Backpressure: head held stable while out_ready is low; push when full is dropped (caller must use credit).
module vregfile_rdseq_skid
    import vregfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = SKID_DEPTH,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CW-1:0]    count
);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [WIDTH:0]  mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    // Pointer and occupancy update; simultaneous push/pop keeps count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and pointers; reset empties the buffer and zeroes the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign out_last  = out_valid & mem_q[rd_ptr_q][WIDTH];
    assign count     = count_q;

endmodule

// File: rtl/vregfile_rdseq.sv
// Read-side sequencer: turns one (base,len[,stride]) command into register file reads and an element stream.
// Latency: accept at T, first a_en at T+1, first out_valid at T+3; 1 element/cycle with out_ready high.
// Backpressure: out_ready low stalls a_en via credit (FIFO occupancy + in-flight read < 2). Optional VREGFILE_RDSEQ_STRIDE_EN adds start_stride.
module vregfile_rdseq
    import vregfile_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 16,
    parameter int LOG2NUMREGS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LOG2NUMREGS-1:0] start_base,
    input  logic [LOG2NUMREGS:0]   start_len,
`ifdef VREGFILE_RDSEQ_STRIDE_EN
    input  logic [LOG2NUMREGS-1:0] start_stride,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [LOG2NUMREGS-1:0] a_reg,
    output logic                   a_en,
    input  logic [WIDTH-1:0]       a_readdataout,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int CW = $clog2(SKID_DEPTH + 1);

    rdseq_state_e           state_q, state_d;
    logic [LOG2NUMREGS-1:0] addr_q, addr_d;
    logic [LOG2NUMREGS:0]   rem_q, rem_d;
    logic [LOG2NUMREGS-1:0] stride_q, stride_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic                   done_q, done_d;

    logic [CW-1:0]          fifo_cnt;
    logic                   pop;
    logic                   credit_ok;
    logic                   issue;
    logic [LOG2NUMREGS:0]   len_c;

    // Command acceptance, per-element issue and completion detection.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        stride_d        = stride_q;
        done_d          = 1'b0;
        pop             = out_valid & out_ready;
        len_c           = (LOG2NUMREGS + 1)'(clamp_len(32'(start_len), int'(NUMREGS)));
        // A read issued now lands in the FIFO one edge after next; reserve room for it.
        credit_ok       = (3'(fifo_cnt) + 3'(inflight_q)) < (3'd2 + 3'(pop));
        issue           = (state_q == ST_ISSUE) && credit_ok;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (LOG2NUMREGS + 1)'(1));
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        addr_d  = start_base;
                        rem_d   = len_c;
`ifdef VREGFILE_RDSEQ_STRIDE_EN
                        stride_d = start_stride;
`else
                        stride_d = LOG2NUMREGS'(1);
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (LOG2NUMREGS + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state; reset abandons any command and in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            stride_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            stride_q        <= stride_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    vregfile_rdseq_skid #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (reset),
        .push      (inflight_q),
        .push_data (a_readdataout),
        .push_last (inflight_last_q),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (fifo_cnt)
    );

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign a_reg = addr_q;
    assign a_en  = issue;

endmodule

// File: tb/tb_vregfile_rdseq.sv
// Bench for vregfile_rdseq: models a 1-cycle registered-read register file,
// checks directed command tables, corner sequences and randomized commands against a queue model.
module tb_vregfile_rdseq;

    localparam int W = 32;
    localparam int N = 16;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [L-1:0] start_base;
    logic [L:0]   start_len;
`ifdef VREGFILE_RDSEQ_STRIDE_EN
    logic [L-1:0] start_stride;
`endif
    logic         busy, done, a_en, out_valid, out_ready, out_last;
    logic [L-1:0] a_reg;
    logic [W-1:0] out_data;
    logic [W-1:0] q_b = '0;
    logic [W-1:0] mem [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Register file: address registered on a_en, data valid the next cycle.
    always @(posedge clk) begin
        if (a_en) q_b <= mem[a_reg];
    end

    vregfile_rdseq #(.WIDTH(W), .NUMREGS(N), .LOG2NUMREGS(L)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_base    (start_base),
        .start_len     (start_len),
`ifdef VREGFILE_RDSEQ_STRIDE_EN
        .start_stride  (start_stride),
`endif
        .busy          (busy),
        .done          (done),
        .a_reg         (a_reg),
        .a_en          (a_en),
        .a_readdataout (q_b),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int eff_stride(input int s);
`ifdef VREGFILE_RDSEQ_STRIDE_EN
        return s % N;
`else
        return (s * 0) + 1;
`endif
    endfunction

    // Runs one command; model streams mem[(base + i*stride) mod N] for i < min(len,N).
    task automatic run_cmd(input int base, input int len, input int stride, input bit rnd,
                           input int extra_k, input int abort_hs,
                           output int n_hs, output int first_k, output int done_k,
                           output logic [W-1:0] first_d, output logic [W-1:0] last_d);
        int exp_n, outst, a;
        bit fin;
        logic [W-1:0] qd[$];
        bit ql[$];
        int qa[$];
        logic pv, pr, pl;
        logic [W-1:0] pd;
        exp_n = (len > N) ? N : len;
        for (int i = 0; i < exp_n; i++) begin
            a = (base + i * eff_stride(stride)) % N;
            qa.push_back(a);
            qd.push_back(mem[a]);
            ql.push_back(i == exp_n - 1);
        end
        @(negedge clk);
        start      = 1'b1;
        start_base = L'(base);
        start_len  = (L + 1)'(len);
`ifdef VREGFILE_RDSEQ_STRIDE_EN
        start_stride = L'(stride);
`endif
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_hs = 0; first_k = -1; done_k = -1; first_d = '0; last_d = '0;
        outst = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int k = 1; k <= 400 && !fin; k++) begin
            if (k > 1) @(negedge clk);
            if (k == extra_k) begin
                start = 1'b1; start_base = 4'd8; start_len = 5'd5;
            end else begin
                start = 1'b0;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
                check("hold_last", out_last, pl);
            end
            if (a_en) begin
                outst++;
                if (qa.size() == 0) check("extra_a_en", a_en, 0);
                else check("a_reg", a_reg, qa.pop_front());
            end
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready) begin
                outst--;
                if (n_hs == 0) first_d = out_data;
                last_d = out_data;
                n_hs++;
                if (qd.size() == 0) check("extra_elem", out_valid, 0);
                else begin
                    check("out_data", out_data, qd.pop_front());
                    check("out_last", out_last, ql.pop_front());
                end
            end
            check("credit_window", outst <= 2, 1);
            if (done) begin
                done_k = k;
                check("busy_at_done", busy, 0);
                fin = 1'b1;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (abort_hs > 0 && n_hs == abort_hs && !fin) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_a_en", a_en, 0);
                check("rst_a_reg", a_reg, 0);
                check("rst_valid", out_valid, 0);
                check("rst_last", out_last, 0);
                check("rst_data", out_data, 0);
                reset = 1'b0;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        check("cmd_timeout", fin, 1);
        if (abort_hs == 0) check("stream_complete", qd.size(), 0);
    endtask

    typedef struct {
        int base; int len; int stride;
        int exp_n; logic [W-1:0] exp_first; logic [W-1:0] exp_last;
        int exp_first_k; int exp_done_k;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int n, fk, dk, len, exp_n;
        logic [W-1:0] fd, ld;
        bit rnd;

        vecs.push_back('{2, 4, 1, 4, 32'h102, 32'h105, 3, 7});
        vecs.push_back('{14, 4, 1, 4, 32'h10E, 32'h101, 3, 7});
        vecs.push_back('{0, 1, 1, 1, 32'h100, 32'h100, 3, 4});
        vecs.push_back('{5, 16, 1, 16, 32'h105, 32'h104, 3, 19});
        vecs.push_back('{9, 20, 1, 16, 32'h109, 32'h108, 3, 19});
        vecs.push_back('{7, 0, 1, 0, 32'h0, 32'h0, -1, 1});
`ifdef VREGFILE_RDSEQ_STRIDE_EN
        vecs.push_back('{1, 6, 3, 6, 32'h101, 32'h100, 3, 9});
        vecs.push_back('{3, 5, 0, 5, 32'h103, 32'h103, 3, 8});
        vecs.push_back('{1, 20, 3, 16, 32'h101, 32'h10E, 3, 19});
`endif

        for (int i = 0; i < N; i++) mem[i] = 32'h100 + i;
        reset = 1'b1; start = 1'b0; start_base = '0; start_len = '0; out_ready = 1'b1;
`ifdef VREGFILE_RDSEQ_STRIDE_EN
        start_stride = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_a_en", a_en, 0);
        check("reset_a_reg", a_reg, 0);
        check("reset_valid", out_valid, 0);
        check("reset_last", out_last, 0);
        check("reset_data", out_data, 0);
        reset = 1'b0;

        // Directed table with out_ready held high.
        foreach (vecs[v]) begin
            run_cmd(vecs[v].base, vecs[v].len, vecs[v].stride, 1'b0, 0, 0, n, fk, dk, fd, ld);
            check($sformatf("vec%0d_count", v), n, vecs[v].exp_n);
            check($sformatf("vec%0d_first_data", v), fd, vecs[v].exp_first);
            check($sformatf("vec%0d_last_data", v), ld, vecs[v].exp_last);
            check($sformatf("vec%0d_first_valid_k", v), fk, vecs[v].exp_first_k);
            check($sformatf("vec%0d_done_k", v), dk, vecs[v].exp_done_k);
        end

        // len=8 with random backpressure: order, no loss, credit window.
        for (int r = 0; r < 4; r++) begin
            run_cmd(r * 3, 8, 1, 1'b1, 0, 0, n, fk, dk, fd, ld);
            check("bp_count", n, 8);
            check("bp_first_valid_k", fk, 3);
        end

        // len=0 then a start arriving while a len=3 command is busy.
        run_cmd(4, 0, 1, 1'b0, 0, 0, n, fk, dk, fd, ld);
        check("len0_done_k", dk, 1);
        check("len0_count", n, 0);
        run_cmd(0, 3, 1, 1'b0, 2, 0, n, fk, dk, fd, ld);
        check("busy_start_count", n, 3);
        check("busy_start_done_k", dk, 6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("quiet_a_en", a_en, 0);
            check("quiet_busy", busy, 0);
            check("quiet_valid", out_valid, 0);
        end

        // Reset during element 2 of a len=6 command, then a fresh command.
        run_cmd(0, 6, 1, 1'b0, 0, 2, n, fk, dk, fd, ld);
        check("abort_no_done", dk, -1);
        run_cmd(0, 2, 1, 1'b0, 0, 0, n, fk, dk, fd, ld);
        check("post_rst_count", n, 2);
        check("post_rst_first", fd, 32'h100);
        check("post_rst_last", ld, 32'h101);
        check("post_rst_done_k", dk, 5);

        // Randomized commands against the queue model.
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            len   = $urandom_range(0, 20);
            rnd   = 1'($urandom_range(0, 1));
            exp_n = (len > N) ? N : len;
            run_cmd($urandom_range(0, N - 1), len, $urandom_range(0, N - 1), rnd, 0, 0,
                    n, fk, dk, fd, ld);
            check("rand_count", n, exp_n);
            if (!rnd) check("rand_done_k", dk, (exp_n == 0) ? 1 : exp_n + 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
